// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame sequencer for a serial 1011 pattern detector.
// Takes len parallel words over a valid/ready handshake and shifts each one
// MSB-first into an enable-qualified detector. It counts detector hits per
// frame and pulses done when the frame is complete.
//
// Handshake: a word transfers on a cycle where word_valid and word_ready are
// both high. word_in is ignored on every other cycle. word_ready is high only
// in LOAD and on the last bit of a word that still has words after it. It is
// forced low when abort is high.
module seq_scan_ctrl #(
    parameter int W     = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             rs,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [W-1:0]     word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_en,
    output logic             det_clr,
    input  logic             det_hit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       dbg_state
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_words_left;
    logic [W-1:0]       r_shreg;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_bit_en_d;
    logic               w_last_bit;
    logic               w_more_words;
    logic               w_accept;

    assign w_last_bit   = (r_bit_idx == '0);
    assign w_more_words = (r_words_left > LEN_W'(1));
    assign w_accept     = word_valid & word_ready;

    assign bit_out   = bit_en & r_shreg[W-1];
    assign busy      = (r_state != S_IDLE);
    assign match_cnt = r_match_cnt;
    assign dbg_state = r_state;

    // State register
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore/handshake outputs; abort overrides everything
    always_comb begin
        w_next     = r_state;
        word_ready = 1'b0;
        bit_en     = 1'b0;
        det_clr    = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_CLR : S_DONE;
                end
            end
            S_CLR: begin
                det_clr = 1'b1;
                w_next  = S_LOAD;
            end
            S_LOAD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bit_en = 1'b1;
                if (w_last_bit) begin
                    if (w_more_words) begin
                        // Offer the next word on the last bit so a ready
                        // source keeps the bit stream gap-free.
                        word_ready = 1'b1;
                        if (!word_valid) begin
                            w_next = S_LOAD;
                        end
                    end else begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            word_ready = 1'b0;
            bit_en     = 1'b0;
            done       = 1'b0;
        end
    end

    // Datapath: word latch and shift, word/bit counters, hit counter
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            r_words_left <= '0;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_match_cnt  <= '0;
            r_bit_en_d   <= 1'b0;
        end else begin
            r_bit_en_d <= bit_en;

            if ((r_state == S_IDLE) && start && (len != '0)) begin
                r_words_left <= len;
            end else if (bit_en && w_last_bit) begin
                r_words_left <= r_words_left - LEN_W'(1);
            end

            if (w_accept) begin
                r_shreg   <= word_in;
                r_bit_idx <= IDX_W'(W - 1);
            end else if (bit_en) begin
                r_shreg   <= {r_shreg[W-2:0], 1'b0};
                r_bit_idx <= r_bit_idx - IDX_W'(1);
            end

            // The detector output one cycle after a bit_en cycle reflects
            // exactly that bit. Qualifying with r_bit_en_d counts each bit
            // at most once, even while det_hit stays high through a stall.
            if (r_state == S_IDLE) begin
                if (start && (len == '0)) begin
                    r_match_cnt <= '0;
                end
            end else if (r_state == S_CLR) begin
                r_match_cnt <= '0;
            end else if (!abort && det_hit && r_bit_en_d && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. A behavioural overlapping-1011 Moore
// detector closes the loop. A second instance with a 2-bit counter shares
// all inputs so that counter saturation can be observed.
module tb_seq_scan_ctrl;

    logic       ck;
    logic       rs;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready, bit_out, bit_en, det_clr, det_hit, busy, done;
    logic [7:0] match_cnt;
    logic [2:0] dbg_state;
    logic       word_ready2, bit_out2, bit_en2, det_clr2, busy2, done2;
    logic [1:0] match_cnt2;
    logic [2:0] dbg_state2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    seq_scan_ctrl #(.W(8), .LEN_W(8), .CNT_W(8)) u_dut (
        .ck(ck), .rs(rs), .start(start), .len(len), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .bit_out(bit_out), .bit_en(bit_en), .det_clr(det_clr), .det_hit(det_hit),
        .busy(busy), .done(done), .match_cnt(match_cnt), .dbg_state(dbg_state)
    );

    seq_scan_ctrl #(.W(8), .LEN_W(8), .CNT_W(2)) u_dut_sat (
        .ck(ck), .rs(rs), .start(start), .len(len), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready2),
        .bit_out(bit_out2), .bit_en(bit_en2), .det_clr(det_clr2), .det_hit(det_hit),
        .busy(busy2), .done(done2), .match_cnt(match_cnt2), .dbg_state(dbg_state2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    always @(posedge ck) cyc <= cyc + 1;

    // ---------------- detector model (overlapping 1011, Moore) ----------------
    logic [3:0] m_hist;
    logic [2:0] m_n;
    assign det_hit = (m_n == 3'd4) && (m_hist == 4'b1011);

    always @(posedge ck or posedge rs) begin
        if (rs) begin
            m_hist <= '0;
            m_n    <= '0;
        end else if (det_clr) begin
            m_hist <= '0;
            m_n    <= '0;
        end else if (bit_en) begin
            m_hist <= {m_hist[2:0], bit_out};
            if (m_n < 3'd4) m_n <= m_n + 3'd1;
        end
    end

    // ---------------- monitor (samples mid-cycle) ----------------
    // Cycle index = number of the rising edge that ends the cycle.
    bit mon_bits[$];
    int first_en, last_en, done_cnt, done_idx, clr_cnt, bad_out;

    always @(negedge ck) begin
        if (bit_en) begin
            mon_bits.push_back(bit_out);
            if (first_en < 0) first_en = cyc + 1;
            last_en = cyc + 1;
        end else if (bit_out) begin
            bad_out++;
        end
        if (done) begin
            done_cnt++;
            done_idx = cyc + 1;
        end
        if (det_clr) clr_cnt++;
    end

    // ---------------- driver tasks ----------------
    int start_idx;

    task automatic clear_mon();
        mon_bits.delete();
        first_en = -1;
        last_en  = -1;
        done_cnt = 0;
        done_idx = -1;
        clr_cnt  = 0;
        bad_out  = 0;
    endtask

    function automatic logic [15:0] bits_vec();
        logic [15:0] v;
        v = '0;
        foreach (mon_bits[i]) v = {v[14:0], mon_bits[i]};
        return v;
    endfunction

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic begin_frame(input logic [7:0] l);
        start     = 1'b1;
        len       = l;
        start_idx = cyc + 1;
        @(posedge ck); #2;
        start = 1'b0;
        len   = 8'hEE;
    endtask

    // Present a word, withholding it for 'gap' ready cycles first.
    task automatic give_word(input logic [7:0] w, input int gap);
        bit acc;
        int seen;
        int n;
        acc = 0; seen = 0; n = 0;
        word_in    = w;
        word_valid = (gap == 0);
        while (!acc && n < 200) begin
            @(negedge ck);
            if (word_ready && word_valid) acc = 1;
            else if (word_ready) seen++;
            @(posedge ck); #2;
            if (!acc && seen >= gap) word_valid = 1'b1;
            n++;
        end
        word_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL word_accept got=timeout exp=accepted word=%h", w);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge ck);
            n++;
        end while (busy && n < 300);
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL wait_idle got=busy exp=idle");
        end
        @(posedge ck); #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rs = 1'b1; start = 0; len = 0; abort = 0; word_in = 0; word_valid = 0;
        clear_mon();
        repeat (3) @(posedge ck);
        #2;
        n_cmp++;
        if ({busy, done, bit_en, bit_out, word_ready, det_clr} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outs got=%b exp=000000", {busy, done, bit_en, bit_out, word_ready, det_clr});
        end
        rs = 1'b0;
        @(posedge ck); #2;
        n_cmp++;
        if (match_cnt !== 8'd0 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state got=cnt %0d st %0d exp=cnt 0 st 0", match_cnt, dbg_state);
        end
    endtask

    task automatic test_single_word();
        clear_mon();
        begin_frame(8'd1);
        give_word(8'hB6, 0);
        wait_idle();
        n_cmp++;
        if (mon_bits.size() !== 8 || bits_vec() !== 16'h00B6) begin
            n_err++;
            $display("FAIL single_bits got=%0d bits %h exp=8 bits 00b6", mon_bits.size(), bits_vec());
        end
        n_cmp++;
        if (first_en !== start_idx + 3 || last_en !== start_idx + 10) begin
            n_err++;
            $display("FAIL single_en_window got=%0d..%0d exp=%0d..%0d", first_en, last_en, start_idx + 3, start_idx + 10);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_idx !== start_idx + 12) begin
            n_err++;
            $display("FAIL single_done got=cnt %0d at %0d exp=cnt 1 at %0d", done_cnt, done_idx, start_idx + 12);
        end
        n_cmp++;
        if (match_cnt !== 8'd2 || match_cnt2 !== 2'd2) begin
            n_err++;
            $display("FAIL single_match got=%0d/%0d exp=2/2", match_cnt, match_cnt2);
        end
        n_cmp++;
        if (clr_cnt !== 1 || bad_out !== 0) begin
            n_err++;
            $display("FAIL single_clr_bitout got=clr %0d bad %0d exp=clr 1 bad 0", clr_cnt, bad_out);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        begin_frame(8'd2);
        give_word(8'hB6, 0);
        give_word(8'hB6, 0);
        wait_idle();
        n_cmp++;
        if (mon_bits.size() !== 16 || bits_vec() !== 16'hB6B6) begin
            n_err++;
            $display("FAIL b2b_bits got=%0d bits %h exp=16 bits b6b6", mon_bits.size(), bits_vec());
        end
        n_cmp++;
        if (first_en !== start_idx + 3 || last_en !== start_idx + 18) begin
            n_err++;
            $display("FAIL b2b_en_window got=%0d..%0d exp=%0d..%0d", first_en, last_en, start_idx + 3, start_idx + 18);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_idx !== start_idx + 20) begin
            n_err++;
            $display("FAIL b2b_done got=cnt %0d at %0d exp=cnt 1 at %0d", done_cnt, done_idx, start_idx + 20);
        end
        n_cmp++;
        if (match_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL b2b_match got=%0d exp=4", match_cnt);
        end
        n_cmp++;
        if (match_cnt2 !== 2'd3) begin
            n_err++;
            $display("FAIL sat_match got=%0d exp=3", match_cnt2);
        end
    endtask

    task automatic test_stall();
        clear_mon();
        begin_frame(8'd2);
        give_word(8'hB6, 0);
        give_word(8'hB6, 3);
        wait_idle();
        n_cmp++;
        if (mon_bits.size() !== 16 || bits_vec() !== 16'hB6B6) begin
            n_err++;
            $display("FAIL stall_bits got=%0d bits %h exp=16 bits b6b6", mon_bits.size(), bits_vec());
        end
        n_cmp++;
        if (last_en - first_en + 1 !== 19) begin
            n_err++;
            $display("FAIL stall_span got=%0d exp=19", last_en - first_en + 1);
        end
        n_cmp++;
        if (clr_cnt !== 1 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL stall_clr_done got=clr %0d done %0d exp=clr 1 done 1", clr_cnt, done_cnt);
        end
        n_cmp++;
        if (match_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL stall_match got=%0d exp=4", match_cnt);
        end
    endtask

    task automatic test_len_zero();
        clear_mon();
        begin_frame(8'd0);
        wait_idle();
        n_cmp++;
        if (done_cnt !== 1 || done_idx !== start_idx + 1) begin
            n_err++;
            $display("FAIL len0_done got=cnt %0d at %0d exp=cnt 1 at %0d", done_cnt, done_idx, start_idx + 1);
        end
        n_cmp++;
        if (match_cnt !== 8'd0 || clr_cnt !== 0 || mon_bits.size() !== 0) begin
            n_err++;
            $display("FAIL len0_quiet got=cnt %0d clr %0d bits %0d exp=0 0 0", match_cnt, clr_cnt, mon_bits.size());
        end
    endtask

    task automatic test_start_busy();
        clear_mon();
        begin_frame(8'd1);
        give_word(8'h5B, 0);
        @(posedge ck); #2;
        start = 1'b1; len = 8'd5;
        @(posedge ck); #2;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge ck);
        #2;
        n_cmp++;
        if (mon_bits.size() !== 8 || bits_vec() !== 16'h005B) begin
            n_err++;
            $display("FAIL busy_start_bits got=%0d bits %h exp=8 bits 005b", mon_bits.size(), bits_vec());
        end
        n_cmp++;
        if (done_cnt !== 1 || busy !== 1'b0 || match_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL busy_start_end got=done %0d busy %b cnt %0d exp=1 0 2", done_cnt, busy, match_cnt);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        begin_frame(8'd2);
        give_word(8'hB6, 0);
        repeat (6) @(posedge ck);
        #2;
        abort = 1'b1;
        #1;
        n_cmp++;
        if ({busy, bit_en, bit_out, word_ready} !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_cycle got=%b exp=1000", {busy, bit_en, bit_out, word_ready});
        end
        @(posedge ck); #2;
        abort = 1'b0;
        repeat (4) @(posedge ck);
        #2;
        n_cmp++;
        if (busy !== 1'b0 || done_cnt !== 0 || mon_bits.size() !== 6) begin
            n_err++;
            $display("FAIL abort_after got=busy %b done %0d bits %0d exp=0 0 6", busy, done_cnt, mon_bits.size());
        end
        n_cmp++;
        if (match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL abort_match got=%0d exp=1", match_cnt);
        end
        // Abort in LOAD with a word offered: the word must not transfer.
        clear_mon();
        begin_frame(8'd1);
        @(posedge ck); #2;
        word_in = 8'hFF; word_valid = 1'b1; abort = 1'b1;
        #1;
        n_cmp++;
        if (word_ready !== 1'b0 || dbg_state !== 3'd2) begin
            n_err++;
            $display("FAIL abort_load got=ready %b st %0d exp=ready 0 st 2", word_ready, dbg_state);
        end
        @(posedge ck); #2;
        abort = 1'b0;
        repeat (5) @(posedge ck);
        #2;
        word_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done_cnt !== 0 || mon_bits.size() !== 0) begin
            n_err++;
            $display("FAIL abort_load_after got=busy %b done %0d bits %0d exp=0 0 0", busy, done_cnt, mon_bits.size());
        end
    endtask

    task automatic test_reset_mid_shift();
        clear_mon();
        begin_frame(8'd1);
        give_word(8'hB6, 0);
        repeat (5) @(posedge ck);
        #2;
        n_cmp++;
        if (match_cnt !== 8'd1 || bit_out !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got=cnt %0d bit %b exp=cnt 1 bit 1", match_cnt, bit_out);
        end
        rs = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, bit_en, bit_out, word_ready, det_clr} !== 6'b0 || match_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mid_reset got=%b cnt %0d exp=000000 cnt 0",
                     {busy, done, bit_en, bit_out, word_ready, det_clr}, match_cnt);
        end
        @(posedge ck); #2;
        rs = 1'b0;
        repeat (12) @(posedge ck);
        #2;
        n_cmp++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset got=done %0d busy %b exp=0 0", done_cnt, busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_len_zero();
        test_start_busy();
        test_abort();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
